// File: rtl/if_id_hazard_controller.sv
// IF/ID hazard sequencing: stall/flush/advance of IF/ID and PC, ID/EX bubble, stall-cycle counter.
// Optional MDU HI/LO interlock counter is built only when HAZARD_MDU_INTERLOCK_EN is defined.
module if_id_hazard_controller #(
    parameter int MDU_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ifidInstr,
    input  logic        idexRegWrite,
    input  logic        idexMemRead,
    input  logic [4:0]  idexRd,
    input  logic        exmemMemRead,
    input  logic [4:0]  exmemRd,
    input  logic        branchTaken,
    input  logic        jump,
    output logic        hazardIFDWrite,
    output logic        hazardIFFlush,
    output logic        hazardPCHold,
    output logic        hazardIDEXBubble,
    output logic [15:0] stallCycles
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_nop;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_branch;
    logic       is_mdu;
    logic       reads_hilo;
    logic       idex_match;
    logic       exmem_match;
    logic       load_use;
    logic       br_dep_ex;
    logic       br_dep_mem;
    logic       mdu_wait;
    logic       stall;
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;
    logic        unused_fields;

    assign op    = ifidInstr[31:26];
    assign rs    = ifidInstr[25:21];
    assign rt    = ifidInstr[20:16];
    assign funct = ifidInstr[5:0];

    // rd and shamt never take part in hazard detection.
    assign unused_fields = ^ifidInstr[15:6];

    assign is_nop     = (ifidInstr == 32'd0);
    assign uses_rs    = !is_nop && (op != 6'd2) && (op != 6'd3);
    assign uses_rt    = !is_nop && ((op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'h2B));
    assign is_branch  = (op == 6'd1) || (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7);
    assign is_mdu     = (op == 6'd0) && (funct >= 6'h18) && (funct <= 6'h1B);
    assign reads_hilo = (op == 6'd0) && ((funct == 6'h10) || (funct == 6'h12));

    // $0 is hardwired, so a write to it can never be a real dependency.
    assign idex_match  = (idexRd != 5'd0) &&
                         ((uses_rs && (rs == idexRd)) || (uses_rt && (rt == idexRd)));
    assign exmem_match = (exmemRd != 5'd0) &&
                         ((uses_rs && (rs == exmemRd)) || (uses_rt && (rt == exmemRd)));

    assign load_use   = idexMemRead & idex_match;
    assign br_dep_ex  = is_branch & idexRegWrite & idex_match;
    assign br_dep_mem = is_branch & exmemMemRead & exmem_match;

`ifdef HAZARD_MDU_INTERLOCK_EN
    logic [3:0] mdu_count_q;
    logic [3:0] mdu_count_d;

    assign mdu_wait = (reads_hilo | is_mdu) && (mdu_count_q != 4'd0);

    always_comb begin
        mdu_count_d = mdu_count_q;
        if (is_mdu && !stall) begin
            mdu_count_d = 4'(MDU_LATENCY);
        end else if (mdu_count_q != 4'd0) begin
            mdu_count_d = mdu_count_q - 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mdu_count_q <= 4'd0;
        end else begin
            mdu_count_q <= mdu_count_d;
        end
    end
`else
    logic unused_mdu;

    // Without the interlock, software pads HI/LO reads with nops.
    assign mdu_wait   = 1'b0;
    assign unused_mdu = ^{is_mdu, reads_hilo, 4'(MDU_LATENCY)};
`endif

    assign stall = load_use | br_dep_ex | br_dep_mem | mdu_wait;

    // A redirect seen during a stall is dropped; the branch re-resolves once ID advances.
    always_comb begin
        hazardIFDWrite   = 1'b0;
        hazardIFFlush    = 1'b0;
        hazardPCHold     = 1'b0;
        hazardIDEXBubble = 1'b0;
        if (Reset) begin
            hazardIFFlush = 1'b1;
        end else if (stall) begin
            hazardIFDWrite   = 1'b1;
            hazardPCHold     = 1'b1;
            hazardIDEXBubble = 1'b1;
        end else if (branchTaken || jump) begin
            hazardIFFlush = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_if_id_hazard_controller.sv
// Directed bench for if_id_hazard_controller; hazard vector is {IFDWrite, IFFlush, PCHold, IDEXBubble}.
module tb_if_id_hazard_controller;

    localparam logic [31:0] NOP      = 32'd0;
    localparam logic [31:0] ADD_9_8  = {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] BEQ_8_0  = {6'd4, 5'd8, 5'd0, 16'd4};
    localparam logic [31:0] MULT_8_9 = {6'd0, 5'd8, 5'd9, 10'd0, 6'h18};
    localparam logic [31:0] MFLO_10  = {6'd0, 10'd0, 5'd10, 5'd0, 6'h12};
`ifdef HAZARD_MDU_INTERLOCK_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif
    localparam logic [3:0] H_NONE  = 4'b0000;
    localparam logic [3:0] H_STALL = 4'b1011;
    localparam logic [3:0] H_FLUSH = 4'b0100;

    logic        Clk;
    logic        Reset;
    logic [31:0] ifidInstr;
    logic        idexRegWrite;
    logic        idexMemRead;
    logic [4:0]  idexRd;
    logic        exmemMemRead;
    logic [4:0]  exmemRd;
    logic        branchTaken;
    logic        jump;
    logic        hazardIFDWrite;
    logic        hazardIFFlush;
    logic        hazardPCHold;
    logic        hazardIDEXBubble;
    logic [15:0] stallCycles;
    logic [3:0]  hz;

    logic [3:0]  exp_q[$];
    logic [15:0] exp_stalls;
    int          n_checks;
    int          n_pass;

    if_id_hazard_controller #(.MDU_LATENCY(4)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .ifidInstr        (ifidInstr),
        .idexRegWrite     (idexRegWrite),
        .idexMemRead      (idexMemRead),
        .idexRd           (idexRd),
        .exmemMemRead     (exmemMemRead),
        .exmemRd          (exmemRd),
        .branchTaken      (branchTaken),
        .jump             (jump),
        .hazardIFDWrite   (hazardIFDWrite),
        .hazardIFFlush    (hazardIFFlush),
        .hazardPCHold     (hazardPCHold),
        .hazardIDEXBubble (hazardIDEXBubble),
        .stallCycles      (stallCycles)
    );

    assign hz = {hazardIFDWrite, hazardIFFlush, hazardPCHold, hazardIDEXBubble};

    // clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic ex_rw, input logic ex_mr,
                         input logic [4:0] ex_rd, input logic mem_mr, input logic [4:0] mem_rd,
                         input logic br, input logic jmp);
        ifidInstr    = instr;
        idexRegWrite = ex_rw;
        idexMemRead  = ex_mr;
        idexRd       = ex_rd;
        exmemMemRead = mem_mr;
        exmemRd      = mem_rd;
        branchTaken  = br;
        jump         = jmp;
    endtask

    // Checks the combinational hazard vector and the counter value before the coming edge,
    // then advances the counter model by the expected stall.
    task automatic step_check(input string tag, input logic [3:0] exp);
        exp_q.push_back(exp);
        #1;
        check({tag, "_haz"}, {28'd0, hz}, {28'd0, exp_q.pop_front()});
        check({tag, "_cnt"}, {16'd0, stallCycles}, {16'd0, exp_stalls});
        if (exp[3] && (exp_stalls != 16'hFFFF)) exp_stalls++;
    endtask

    task automatic cycle(input string tag, input logic [31:0] instr, input logic ex_rw,
                         input logic ex_mr, input logic [4:0] ex_rd, input logic mem_mr,
                         input logic [4:0] mem_rd, input logic br, input logic jmp,
                         input logic [3:0] exp);
        @(negedge Clk);
        drive(instr, ex_rw, ex_mr, ex_rd, mem_mr, mem_rd, br, jmp);
        step_check(tag, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        exp_stalls = 16'd0;
        Reset      = 1'b1;
        drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("rst_haz", {28'd0, hz}, {28'd0, H_FLUSH});
        check("rst_cnt", {16'd0, stallCycles}, 32'd0);

        @(negedge Clk);
        Reset = 1'b0;
        step_check("nop", H_NONE);

        // load-use: one stall, then the load sits in MEM and add proceeds
        cycle("loaduse",      ADD_9_8, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, H_STALL);
        cycle("loaduse_go",   ADD_9_8, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, H_NONE);
        // ALU producer feeding a non-branch is forwarded
        cycle("alu_fwd",      ADD_9_8, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);

        // branch after load: EX then MEM dependency, then taken
        cycle("brld_ex",      BEQ_8_0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, H_STALL);
        cycle("brld_mem",     BEQ_8_0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, H_STALL);
        cycle("brld_taken",   BEQ_8_0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, H_FLUSH);
        cycle("after_flush",  NOP,     1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);

        // branch against $0 never stalls; ALU producer costs one cycle
        cycle("br_rd0",       BEQ_8_0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);
        cycle("bralu_ex",     BEQ_8_0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, H_STALL);
        cycle("bralu_go",     BEQ_8_0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, H_NONE);

        // redirect during a stall is ignored, then honoured
        cycle("lu_jump",      ADD_9_8, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, H_STALL);
        cycle("jump_after",   ADD_9_8, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, H_FLUSH);

        // mult then mflo: 4-cycle interlock when built in, none otherwise
        cycle("mult",         MULT_8_9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);
        for (int i = 0; i < 4; i++) begin
            cycle("mflo_wait", MFLO_10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                  MDU_EN ? H_STALL : H_NONE);
        end
        cycle("mflo_go",      MFLO_10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);

        // back-to-back MDU ops
        cycle("mult_a",       MULT_8_9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);
        for (int i = 0; i < 4; i++) begin
            cycle("mult_b_wait", MULT_8_9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                  MDU_EN ? H_STALL : H_NONE);
        end
        cycle("mult_b_go",    MULT_8_9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, H_NONE);
        cycle("mflo_pre_rst", MFLO_10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
              MDU_EN ? H_STALL : H_NONE);

        // reset mid-cycle during the MDU wait
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_haz", {28'd0, hz}, {28'd0, H_FLUSH});
        check("midrst_cnt", {16'd0, stallCycles}, 32'd0);
        exp_stalls = 16'd0;
        @(negedge Clk);
        Reset = 1'b0;
        step_check("mflo_after_rst", H_NONE);

        // saturation of the stall counter
        cycle("sat_start",    ADD_9_8, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, H_STALL);
        repeat (65539) @(posedge Clk);
        #1;
        check("sat_ffff", {16'd0, stallCycles}, 32'h0000FFFF);
        repeat (3) @(posedge Clk);
        #1;
        check("sat_hold", {16'd0, stallCycles}, 32'h0000FFFF);
        check("sat_haz", {28'd0, hz}, {28'd0, H_STALL});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_controller.md
# if_id_hazard_controller

- Sequences the IF/ID pipeline register and the PC.
- Decodes the instruction currently held in ID against the instructions in ID/EX and EX/MEM.
- Each cycle, decides whether IF/ID holds (stall), loads a nop (flush) or advances; the PC and the ID/EX bubble are kept consistent with that decision.
- Also owns the multiply/divide (MDU) HI/LO interlock counter and a saturating stall-cycle counter for performance debug.

## Interface
- MDU_LATENCY, 4, cycles from an MDU instruction leaving ID until HI/LO are valid (legal 1..15)
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- ifidInstr  input  32  instruction currently in ID (IF/ID output)
- idexRegWrite  input  1  instruction in EX writes a register
- idexMemRead  input  1  instruction in EX is a load
- idexRd  input  5  destination register of instruction in EX (already muxed rt/rd)
- exmemMemRead  input  1  instruction in MEM is a load
- exmemRd  input  5  destination register of instruction in MEM
- branchTaken  input  1  branch in ID resolved taken this cycle
- jump  input  1  j/jal/jr in ID this cycle
- hazardIFDWrite  output  1  1 = IF/ID holds its contents
- hazardIFFlush  output  1  1 = IF/ID loads 32'd0 (wins over hold)
- hazardPCHold  output  1  1 = PC does not update
- hazardIDEXBubble  output  1  1 = ID/EX control fields forced to zero
- stallCycles  output  16  saturating count of stall cycles since reset

## Operation
- Decode of ifidInstr: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0]; instruction 32'd0 reads nothing.
- usesRs: every op except 2, 3, and except a nop.
- usesRt: op 0, 4, 5, 0x2B.
- isBranch: op 1, 4, 5, 6, 7.
- isMdu: op 0 and funct 0x18..0x1B.
- readsHiLo: op 0 and funct 0x10 or 0x12.
- Register $0 never causes a hazard.
- Hazard terms:
  - loadUse: idexMemRead and idexRd matches a used source.
  - brDepEx: isBranch, idexRegWrite and idexRd matches a used source.
  - brDepMem: isBranch, exmemMemRead and exmemRd matches a used source.
  - mduWait: (readsHiLo or isMdu) and mduCount≠0.
- stall = loadUse | brDepEx | brDepMem | mduWait.
- stall=1 drives hazardIFDWrite=1, hazardPCHold=1, hazardIDEXBubble=1, hazardIFFlush=0.
- A branchTaken/jump that arrives during a stall is ignored; the branch is re-evaluated once the stall clears.
- stall=0 with (branchTaken|jump) drives hazardIFFlush=1 and all other outputs 0.
  - PC loads the target.
  - The instruction in ID advances; the fetched one is squashed.
- Otherwise all outputs are 0.
- mduCount (4 bits): loaded with MDU_LATENCY when isMdu and stall=0; else decrements if nonzero; holds at 0.
- stallCycles increments on every cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- All four hazard outputs are combinational from inputs, mduCount and Reset; they are valid before the same rising edge at which IF/ID samples.
- mduCount and stallCycles update on the rising edge of Clk.
- Reset asserted (async):
  - mduCount=0 and stallCycles=0 immediately.
  - hazardIFFlush=1 so IF/ID fills with nop; other hazard outputs are 0.
- First edge after Reset deasserts: normal decode.
- Reset mid-MDU-wait: counter cleared; no residual stall after release.
- Load-use costs exactly 1 stall cycle.
- Branch after ALU producer: 1 cycle. Branch after load: 2 cycles (1 via brDepEx, then 1 via brDepMem).
- mfhi immediately after mult with MDU_LATENCY=4: 4 stall cycles.
  - Stalls while mduCount=4,3,2,1; advances when mduCount=0.
- Back-to-back MDU instructions: the second stalls until mduCount=0, then reloads.
- Simultaneous loadUse and branchTaken: stall only, no flush.

## Configuration
- HAZARD_MDU_INTERLOCK_EN defined: mduCount and the mduWait term are present as above.
- HAZARD_MDU_INTERLOCK_EN undefined: no mduCount register and mduWait=0. mfhi/mflo/MDU ops never stall; software must pad with nops.
- MDU_LATENCY is still accepted but unused when the macro is undefined.

## Test plan
- Assert Reset mid-cycle -> hazardIFFlush=1 at once, stallCycles=0; deassert, feed nop -> all hazard outputs 0.
- Load-use: idexMemRead=1, idexRd=8, ifidInstr=add $9,$8,$10 -> one cycle with hazardIFDWrite=hazardPCHold=hazardIDEXBubble=1; stallCycles=1.
- Branch after load: beq $8,$0 with load to $8 in EX, then in MEM -> 2 stall cycles; then branchTaken=1 -> hazardIFFlush=1 for one cycle.
- Branch with idexRd=0, idexRegWrite=1 -> no stall.
- mult then mflo, MDU_LATENCY=4, macro defined -> mflo stalls exactly 4 cycles. With macro undefined -> 0 stall cycles.
- loadUse and jump asserted together -> stall, hazardIFFlush=0. Next cycle jump still asserted -> hazardIFFlush=1.
- Force 65 540 stall cycles -> stallCycles holds 16'hFFFF.
